// File: rtl/l2_cache_control.sv
// Sequencing FSM for the 8-way, 8-set L2 cache: hit decode, writeback/fetch to memory, replacement state.
// Define L2_PLRU_EN for per-set tree pseudo-LRU; otherwise a global round-robin pointer picks victims.
module l2_cache_control (
   input  logic        clk,
   input  logic        reset,
   input  logic        L2_read,
   input  logic        L2_write,
   input  logic [15:0] L2_address,
   output logic        L2_resp,
   input  logic [7:0]  hit,
   input  logic [7:0]  valid_bits,
   input  logic [7:0]  dirty_bits,
   output logic [2:0]  waydatamux_sel,
   output logic [7:0]  way_write,
   output logic        datainmux_sel,
   output logic        valid_in,
   output logic        dirty_in,
   output logic        pmemaddrmux_sel,
   output logic        pmem_read,
   output logic        pmem_write,
   input  logic        pmem_resp
);

   typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_WRITEBACK, S_FETCH} state_t;

   state_t      r_state, w_next;
   logic        r_is_write, r_wb_done;
   logic [2:0]  r_victim;
   logic [2:0]  w_index, w_hit_way, w_inv_way, w_repl_way, w_victim;
   logic        w_hit_any, w_inv_any, w_alloc;
   logic        w_unused_addr;

   function automatic logic [2:0] lowest_set(input logic [7:0] v);
      lowest_set = 3'd0;
      for (int i = 7; i >= 0; i--)
         if (v[i]) lowest_set = i[2:0];
   endfunction

   assign w_index       = L2_address[4:2];
   assign w_unused_addr = ^{L2_address[15:5], L2_address[1:0]};
   assign w_hit_any     = |hit;
   assign w_hit_way     = lowest_set(hit);
   assign w_inv_any     = ~&valid_bits;
   assign w_inv_way     = lowest_set(~valid_bits);
   assign w_victim      = w_inv_any ? w_inv_way : w_repl_way;

`ifdef L2_PLRU_EN
   // Tree bit = direction of the LRU side (0 = lower-numbered half).
   logic [6:0] r_plru [8];
   logic [6:0] w_tree;
   logic       w_touch;
   logic [2:0] w_touch_way;

   function automatic logic [6:0] plru_touch(input logic [6:0] t, input logic [2:0] w);
      plru_touch    = t;
      plru_touch[0] = ~w[2];
      if (w[2]) plru_touch[2] = ~w[1];
      else      plru_touch[1] = ~w[1];
      case (w[2:1])
         2'd0:    plru_touch[3] = ~w[0];
         2'd1:    plru_touch[4] = ~w[0];
         2'd2:    plru_touch[5] = ~w[0];
         default: plru_touch[6] = ~w[0];
      endcase
   endfunction

   assign w_tree = r_plru[w_index];

   always_comb begin
      w_repl_way    = 3'd0;
      w_repl_way[2] = w_tree[0];
      w_repl_way[1] = w_tree[0] ? w_tree[2] : w_tree[1];
      case ({w_repl_way[2], w_repl_way[1]})
         2'd0:    w_repl_way[0] = w_tree[3];
         2'd1:    w_repl_way[0] = w_tree[4];
         2'd2:    w_repl_way[0] = w_tree[5];
         default: w_repl_way[0] = w_tree[6];
      endcase
   end

   assign w_touch     = ((r_state == S_LOOKUP) && w_hit_any) || w_alloc;
   assign w_touch_way = (r_state == S_FETCH) ? r_victim : (w_hit_any ? w_hit_way : w_victim);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) r_plru[i] <= 7'd0;
      end else if (w_touch) begin
         r_plru[w_index] <= plru_touch(w_tree, w_touch_way);
      end
   end
`else
   logic [2:0] r_rr;

   assign w_repl_way = r_rr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)        r_rr <= 3'd0;
      else if (w_alloc) r_rr <= r_rr + 3'd1;
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_is_write <= 1'b0;
         r_wb_done  <= 1'b0;
         r_victim   <= 3'd0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE) r_is_write <= L2_write;
         if ((r_state == S_LOOKUP) && !w_hit_any) r_victim <= w_victim;
         // Lets the post-writeback re-lookup of a write treat the victim as clean.
         if (r_state == S_IDLE) r_wb_done <= 1'b0;
         else if ((r_state == S_WRITEBACK) && pmem_resp) r_wb_done <= 1'b1;
      end
   end

   always_comb begin
      w_next          = r_state;
      L2_resp         = 1'b0;
      way_write       = 8'd0;
      waydatamux_sel  = 3'd0;
      datainmux_sel   = 1'b0;
      valid_in        = 1'b0;
      dirty_in        = 1'b0;
      pmemaddrmux_sel = 1'b0;
      pmem_read       = 1'b0;
      pmem_write      = 1'b0;
      w_alloc         = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (L2_read || L2_write) w_next = S_LOOKUP;
         end
         S_LOOKUP: begin
            if (w_hit_any) begin
               waydatamux_sel = w_hit_way;
               L2_resp        = 1'b1;
               if (r_is_write) begin
                  way_write = 8'd1 << w_hit_way;
                  valid_in  = 1'b1;
                  dirty_in  = 1'b1;
               end
               w_next = S_IDLE;
            end else begin
               waydatamux_sel = w_victim;
               if (valid_bits[w_victim] && dirty_bits[w_victim] && !r_wb_done) begin
                  w_next = S_WRITEBACK;
               end else if (!r_is_write) begin
                  w_next = S_FETCH;
               end else begin
                  way_write = 8'd1 << w_victim;
                  valid_in  = 1'b1;
                  dirty_in  = 1'b1;
                  L2_resp   = 1'b1;
                  w_alloc   = 1'b1;
                  w_next    = S_IDLE;
               end
            end
         end
         S_WRITEBACK: begin
            pmem_write      = 1'b1;
            pmemaddrmux_sel = 1'b1;
            waydatamux_sel  = r_victim;
            if (pmem_resp) w_next = r_is_write ? S_LOOKUP : S_FETCH;
         end
         S_FETCH: begin
            pmem_read      = 1'b1;
            waydatamux_sel = r_victim;
            if (pmem_resp) begin
               way_write     = 8'd1 << r_victim;
               datainmux_sel = 1'b1;
               valid_in      = 1'b1;
               w_alloc       = 1'b1;
               w_next        = S_LOOKUP;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

endmodule
